// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared states, parity-mode codes and vote helper for uart_rx_os.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : Line synchroniser, oversample counter and 3-sample centre vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick_os,
    input  logic i_rx_line,
    input  logic i_clr,
    output logic o_s_line,
    output logic o_half_strobe,
    output logic o_sample_strobe,
    output logic o_voted
);

    localparam int             CW     = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  C_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  C_LAST = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [1:0]             r_smp;
    logic                   w_s_line;

    assign w_s_line = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_line};
        end
    end

    // Explicit wrap so non-power-of-two oversample ratios keep the bit period.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_tick_os) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // Holds the two samples preceding the current tick; only meaningful at C_LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp <= 2'b11;
        end else if (i_tick_os) begin
            r_smp <= {r_smp[0], w_s_line};
        end
    end

    assign o_s_line        = w_s_line;
    assign o_half_strobe   = i_tick_os & (r_cnt == C_HALF);
    assign o_sample_strobe = i_tick_os & (r_cnt == C_LAST);
    assign o_voted         = maj3(r_smp[1], r_smp[0], w_s_line);

endmodule

`default_nettype wire

// File: rtl/uart_rx_os.sv
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampling UART receiver with status and valid/ready holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick_os,
    input  logic                 i_rx_line,
    input  logic [1:0]           i_cfg_parity,
    input  logic                 i_cfg_stop2,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_break,
    output logic                 o_rx_overrun,
    output logic                 o_rx_busy
);

    localparam int             BW         = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  C_LAST_BIT = BW'(DATA_BITS - 1);

    state_t                 r_state, w_state_nxt;
    logic [BW-1:0]          r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [1:0]             r_par_mode;
    logic                   r_stop2;
    logic                   r_par_bit;
    logic                   r_ferr;

    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid, r_fe, r_pe, r_bk, r_ovr;

    logic w_s_line, w_half, w_strobe, w_voted, w_clr, w_done;
    logic w_par_en, w_fe, w_pe, w_bk, w_load;

    uart_rx_sampler #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk             (clk),
        .rst             (rst),
        .i_tick_os       (i_tick_os),
        .i_rx_line       (i_rx_line),
        .i_clr           (w_clr),
        .o_s_line        (w_s_line),
        .o_half_strobe   (w_half),
        .o_sample_strobe (w_strobe),
        .o_voted         (w_voted)
    );

    assign w_par_en = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (!w_s_line) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_half) begin
                    if (w_s_line) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                        w_clr       = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_strobe && (r_bit_idx == C_LAST_BIT)) begin
                    w_state_nxt = w_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_strobe) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Completion at the centre of the last stop bit, not its end.
                if (w_strobe && (!r_stop2 || (r_bit_idx != '0))) begin
                    w_done      = 1'b1;
                    w_state_nxt = w_s_line ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (w_s_line) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_mode <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_par_bit  <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (r_state == IDLE && !w_s_line) begin
                r_par_mode <= i_cfg_parity;
                r_stop2    <= i_cfg_stop2;
                r_par_bit  <= 1'b0;
                r_ferr     <= 1'b0;
            end
            if (w_state_nxt != r_state) begin
                r_bit_idx <= '0;
            end else if (w_strobe && (r_state == DATA || r_state == STOP)) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_strobe) begin
                case (r_state)
                    DATA:    r_shift   <= {w_voted, r_shift[DATA_BITS-1:1]};
                    PARITY:  r_par_bit <= w_voted;
                    STOP:    if (!w_voted) r_ferr <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Status of the frame completing this cycle (final stop vote folded in).
    assign w_fe   = r_ferr | ~w_voted;
    assign w_pe   = w_par_en & ((^r_shift ^ r_par_bit) != (r_par_mode == PAR_ODD));
    assign w_bk   = w_fe & (r_shift == '0) & (!w_par_en | !r_par_bit);
    assign w_load = w_done & (!r_valid | i_rx_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_pe    <= 1'b0;
            r_bk    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shift;
                r_fe    <= w_fe;
                r_pe    <= w_pe;
                r_bk    <= w_bk;
                r_valid <= 1'b1;
            end else if (r_valid && i_rx_ready) begin
                r_valid <= 1'b0;
            end
            r_ovr <= w_done & r_valid & ~i_rx_ready;
        end
    end

    assign o_rx_data       = r_data;
    assign o_rx_valid      = r_valid;
    assign o_rx_frame_err  = r_fe;
    assign o_rx_parity_err = r_pe;
    assign o_rx_break      = r_bk;
    assign o_rx_overrun    = r_ovr;
    assign o_rx_busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Directed bench for uart_rx_os (8-bit and 7-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_os;

    localparam int BITCLK = 64;     // 16 ticks x 4 clocks per tick

    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic       line8 = 1'b1, line7 = 1'b1, ready = 1'b1, ready7 = 1'b1;
    logic [1:0] par = 2'b00;
    logic       stop2 = 1'b0;

    logic [7:0] d8;
    logic       v8, fe8, pe8, bk8, ov8, busy8;
    logic [6:0] d7;
    logic       v7, fe7, pe7, bk7, ov7, busy7;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .i_tick_os(tick), .i_rx_line(line8),
        .i_cfg_parity(par), .i_cfg_stop2(stop2),
        .o_rx_data(d8), .o_rx_valid(v8), .i_rx_ready(ready),
        .o_rx_frame_err(fe8), .o_rx_parity_err(pe8), .o_rx_break(bk8),
        .o_rx_overrun(ov8), .o_rx_busy(busy8)
    );

    uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut7 (
        .clk(clk), .rst(rst), .i_tick_os(tick), .i_rx_line(line7),
        .i_cfg_parity(par), .i_cfg_stop2(stop2),
        .o_rx_data(d7), .o_rx_valid(v7), .i_rx_ready(ready7),
        .o_rx_frame_err(fe7), .o_rx_parity_err(pe7), .o_rx_break(bk7),
        .o_rx_overrun(ov7), .o_rx_busy(busy7)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(negedge clk) begin
        tdiv = (tdiv + 1) % 4;
        tick = (tdiv == 0);
    end

    // Frame monitor: latch what the DUT presents on each rising rx_valid.
    int         frames8 = 0, vcyc8 = 0, ovr8 = 0, frames7 = 0, ovr7 = 0;
    logic       prev8 = 1'b0, prev7 = 1'b0;
    logic [7:0] cd8 = '0;
    logic       cfe8 = 1'b0, cpe8 = 1'b0, cbk8 = 1'b0;
    logic [6:0] cd7 = '0;
    logic       cfe7 = 1'b0, cpe7 = 1'b0, cbk7 = 1'b0;

    always @(posedge clk) begin
        #1;
        if (v8 && !prev8) begin
            frames8++;
            cd8 = d8; cfe8 = fe8; cpe8 = pe8; cbk8 = bk8;
        end
        if (v8) vcyc8++;
        if (ov8) ovr8++;
        prev8 = v8;
        if (v7 && !prev7) begin
            frames7++;
            cd7 = d7; cfe7 = fe7; cpe7 = pe7; cbk7 = bk7;
        end
        if (ov7) ovr7++;
        prev7 = v7;
    end

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic clr_cap();
        frames8 = 0; vcyc8 = 0; ovr8 = 0; frames7 = 0; ovr7 = 0;
    endtask

    // One bit period; a set glitch flag inverts the line for 4 clocks mid-bit.
    task automatic hold_bit(input int sel, input logic v, input logic g);
        logic ve;
        for (int k = 0; k < BITCLK; k++) begin
            @(negedge clk);
            ve = (g && k >= 28 && k < 32) ? ~v : v;
            if (sel == 0) line8 = ve; else line7 = ve;
        end
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                              input logic has_par, input logic pbit, input logic two_stop,
                              input logic s1, input logic s2, input logic [8:0] gmask);
        hold_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(sel, d[i], gmask[i]);
        if (has_par) hold_bit(sel, pbit, 1'b0);
        hold_bit(sel, s1, 1'b0);
        if (two_stop) hold_bit(sel, s2, 1'b0);
        @(negedge clk);
        if (sel == 0) line8 = 1'b1; else line7 = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       pbit;
        logic       two;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bk;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    initial begin
        //            data   par    pb    two   s1    s2    exp   pe    fe    bk
        vec[0]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{8'hA3, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
        vec[2]  = '{8'hA3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
        vec[3]  = '{8'h3C, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vec[6]  = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{8'h00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vec[8]  = '{8'h80, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vec[10] = '{8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
        vec[11] = '{8'h01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        check("reset valid", v8, 0);
        check("reset data", d8, 0);
        check("reset busy", busy8, 0);
        check("reset status", {fe8, pe8, bk8, ov8}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            par   = vec[i].par;
            stop2 = vec[i].two;
            clr_cap();
            send_frame(0, {1'b0, vec[i].data}, 8, (vec[i].par == 2'b01 || vec[i].par == 2'b10),
                       vec[i].pbit, vec[i].two, vec[i].s1, vec[i].s2, 9'h000);
            repeat (2 * BITCLK) @(negedge clk);
            check($sformatf("v%0d frames", i), frames8, 1);
            check($sformatf("v%0d valid_cycles", i), vcyc8, 1);
            check($sformatf("v%0d data", i), cd8, vec[i].exp_data);
            check($sformatf("v%0d parity_err", i), cpe8, vec[i].exp_pe);
            check($sformatf("v%0d frame_err", i), cfe8, vec[i].exp_fe);
            check($sformatf("v%0d break", i), cbk8, vec[i].exp_bk);
            check($sformatf("v%0d busy_idle", i), busy8, 0);
        end
        par = 2'b00; stop2 = 1'b0;

        // 4-tick low glitch on an idle line: start seen, then false start.
        clr_cap();
        @(negedge clk); line8 = 1'b0;
        repeat (16) @(negedge clk);
        check("glitch busy", busy8, 1);
        line8 = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch busy_after", busy8, 0);
        check("glitch frames", frames8, 0);

        // 1-tick glitches mid-bit in bits 1 (0->1) and 2 (1->0) are out-voted.
        clr_cap();
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h006);
        repeat (2 * BITCLK) @(negedge clk);
        check("vote frames", frames8, 1);
        check("vote data", cd8, 8'h55);
        check("vote frame_err", cfe8, 0);

        // Line held low for 20 bit times.
        clr_cap();
        @(negedge clk); line8 = 1'b0;
        repeat (20 * BITCLK) @(negedge clk);
        check("break frames", frames8, 1);
        check("break busy_low", busy8, 1);
        check("break data", d8, 8'h00);
        check("break frame_err", fe8, 1);
        check("break flag", bk8, 1);
        line8 = 1'b1;
        repeat (10) @(negedge clk);
        check("break busy_high", busy8, 0);
        check("break frames_end", frames8, 1);

        // Overrun: consumer stalled across two frames.
        clr_cap();
        ready = 1'b0;
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000);
        repeat (2 * BITCLK) @(negedge clk);
        send_frame(0, 9'h034, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000);
        repeat (2 * BITCLK) @(negedge clk);
        check("ovr valid", v8, 1);
        check("ovr data", d8, 8'h12);
        check("ovr pulses", ovr8, 1);
        check("ovr frames", frames8, 1);
        ready = 1'b1;
        @(posedge clk); #1;
        check("ovr valid_drop", v8, 0);
        check("ovr data_kept", d8, 8'h12);

        // Reset in the middle of a frame with a frame still held.
        ready = 1'b0;
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000);
        repeat (2 * BITCLK) @(negedge clk);
        check("mrst held_data", d8, 8'hC3);
        @(negedge clk); line8 = 1'b0;
        repeat (200) @(negedge clk);
        check("mrst busy_before", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst valid", v8, 0);
        check("mrst data", d8, 0);
        check("mrst busy", busy8, 0);
        line8 = 1'b1;
        ready = 1'b1;
        repeat (200) @(negedge clk);

        // 7-bit, odd parity, two stops with the second low; cfg toggled mid-frame.
        clr_cap();
        par = 2'b10; stop2 = 1'b1;
        fork
            send_frame(1, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000);
            begin
                repeat (250) @(negedge clk);
                par = 2'b00; stop2 = 1'b0;
            end
        join
        repeat (2 * BITCLK) @(negedge clk);
        check("d7 frames", frames7, 1);
        check("d7 data", cd7, 7'h41);
        check("d7 frame_err", cfe7, 1);
        check("d7 parity_err", cpe7, 0);
        check("d7 break", cbk7, 0);
        check("d7 overrun", ovr7, 0);
        check("d7 busy", busy7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Next-generation UART receiver for the loopback path.
- Oversamples rx_line on a tick_os pulse, which fires OVERSAMPLE times per bit. Locates the bit centre from the start-bit edge and majority-votes each bit.
- Supports configurable data width, parity and 1/2 stop bits, and reports frame/parity/break/overrun status.
- Delivers each frame through a one-entry valid/ready holding register to the downstream consumer (loopback TX or host logic).

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first.
- OVERSAMPLE, 16: tick_os pulses per bit, legal even values 8..32.
- SYNC_STAGES, 2: rx_line synchroniser depth, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- tick_os  in  1  one-cycle pulse, OVERSAMPLE per bit period
- rx_line  in  1  asynchronous serial input, idle high
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
- cfg_stop2  in  1  1 = two stop bits checked
- rx_data  out  DATA_BITS  received data, valid while rx_valid
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready
- rx_frame_err  out  1  status of held frame: a stop bit sampled low
- rx_parity_err  out  1  status of held frame: parity mismatch
- rx_break  out  1  status of held frame: all data, parity and stop samples low
- rx_overrun  out  1  one-cycle pulse: completed frame dropped
- rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: synchroniser flops = 1; state = IDLE; counters = 0.
- Reset: rx_data, rx_valid, all status outputs, rx_overrun and rx_busy = 0.
- Reset mid-frame aborts the frame; rx_valid and the held data are cleared.
- Sampling: the FSM sees only the synchronised line (s_line); latency is SYNC_STAGES clocks. The counter advances only on tick_os.
- Majority vote: each bit value is the majority of s_line on the ticks where the counter equals OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1 (3 samples around the centre).
- IDLE: s_line == 0 -> START with counter cleared. cfg_parity and cfg_stop2 are latched here; changes mid-frame are ignored.
- START: on the tick where the counter reaches OVERSAMPLE/2-1:
  - s_line == 1 -> IDLE (false start, no output).
  - otherwise -> DATA with counter cleared.
- DATA: each bit completes when the counter reaches OVERSAMPLE-1. Shift in the voted value LSB first. After DATA_BITS bits -> PARITY if parity is enabled, else STOP.
- PARITY: one bit; parity_err = (XOR of data bits ^ voted bit) != (odd ? 1 : 0).
- STOP: one or two bits; any voted stop = 0 sets frame_err.
  - Completion fires at the centre of the final stop bit, not its end.
  - Then go to IDLE if s_line == 1, else WAIT_HIGH.
- break = frame_err & (data == 0) & (parity bit == 0 or parity disabled).
- WAIT_HIGH: stay until s_line == 1, then IDLE. Prevents retriggering during a break or line-stuck-low.
- Completion with rx_valid == 0, or rx_valid & rx_ready in the same cycle:
  - Load rx_data and the three status bits.
  - rx_valid = 1 next clock; no overrun.
- Completion with rx_valid & !rx_ready: frame discarded, held data unchanged, rx_overrun pulses for 1 clock.
- Handshake: rx_valid & rx_ready without completion -> rx_valid = 0 next clock; data and status keep their values.
- rx_valid never drops without rx_ready.
- Counter widths: $clog2(OVERSAMPLE) bits. The bit index covers 0..DATA_BITS-1 and wraps only via state change.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD
  - helper function for the majority of 3
- Sub-module uart_rx_sampler holds the synchroniser chain, the oversample counter and the 3-sample majority register. It outputs s_line, sample_strobe (centre) and the voted bit value.
- The FSM and holding register stay in uart_rx_os.

Test Plan:
- OVERSAMPLE=16, 8N1, rx_ready=1, send 0x55 -> rx_data=0x55, rx_valid 1 clock, all status 0, rx_busy low after the stop centre.
- Even parity, send 0xA3 with parity bit 1 (wrong) -> rx_data=0xA3, rx_parity_err=1. Repeat with parity bit 0 -> rx_parity_err=0.
- Line low for 20 bit times, 8N1 -> rx_data=0x00, rx_frame_err=1, rx_break=1, one frame only, rx_busy stays high until the line returns high.
- rx_ready=0, send 0x12 then 0x34 -> rx_data stays 0x12, rx_overrun pulses once. Then set rx_ready=1 -> rx_valid drops next clock.
- 4-tick low glitch on an idle line -> no rx_valid, FSM returns to IDLE. A 1-tick glitch inside a data bit centre window leaves the voted value unchanged.
- DATA_BITS=7, odd parity, cfg_stop2=1, second stop bit driven low for 0x41 -> rx_data=0x41, rx_frame_err=1. Toggling cfg_parity mid-frame has no effect.
